apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- APB requester that drives the peripheral bus toward the PLIC register slave and other APB peripherals.
- Accepts single read/write commands from a valid/ready command port and runs one APB setup+access transfer per command.
- Honours PREADY wait states, with a bounded timeout.
- Returns read data and error status on a valid/ready response port.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data and PWDATA/PRDATA.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  reset; asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  output  1  PSLVERR seen, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  slave ready.
- PSLVERR  input  1  slave error.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset asserted mid-transfer aborts immediately: PSEL/PENABLE drop asynchronously, and no response is generated.
- All outputs are registered or decoded directly from state; no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: capture cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA; go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0, cmd_ready = 0.
  - Always goes to ACCESS after exactly one cycle.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PREADY = 1: go to RESP and latch the response:
    - rsp_rdata = PRDATA if read, else 0.
    - rsp_err = PSLVERR.
    - rsp_timeout = 0.
  - PREADY = 0: increment the wait counter.
  - Timeout: TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES - 1 with PREADY still 0. Go to RESP with rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
  - PREADY = 1 on the timeout cycle wins: normal completion.
- RESP:
  - PSEL = PENABLE = 0, rsp_valid = 1.
  - rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE, clear rsp_valid, clear the counter.
  - A command is not accepted in RESP.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS, and hold their last value in IDLE/RESP.
- PSEL never deasserts between SETUP and ACCESS.
- Latency: command accepted at cycle N gives SETUP at N+1 and ACCESS at N+2. With zero wait states, rsp_valid is asserted at N+3.
- Maximum throughput is one transfer per 4 cycles, with rsp_ready tied high.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it never wraps because it is cleared on leaving ACCESS.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY = 1; they are ignored otherwise.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum (IDLE, SETUP, ACCESS, RESP).
  - Constant APB_BYTES_PER_WORD = 4.
  - Default width constants, reused by the APB slave side.
- One sub-module, apb_wait_timer:
  - Parameter TIMEOUT_CYCLES.
  - Inputs: clear and count_en.
  - Output: expired.
  - Instantiated once by apb_master_bridge.

Test Plan:
- Write, zero wait: cmd write addr 0x0000_0004, data 0xDEAD_BEEF with PREADY = 1.
  - Required: SETUP one cycle later, ACCESS the cycle after.
  - Required: rsp_valid 3 cycles after accept, with rsp_err = 0 and rsp_rdata = 0.
- Read, 3 wait states: cmd read addr 0x0000_0010; slave holds PREADY = 0 for 3 ACCESS cycles, then PRDATA = 0x0000_00A5.
  - Required: PSEL/PENABLE high for 4 cycles.
  - Required: rsp_rdata = 0xA5, response 6 cycles after accept.
- Slave error: read with PREADY = 1 and PSLVERR = 1.
  - Required: rsp_err = 1, rsp_timeout = 0.
- Timeout: TIMEOUT_CYCLES = 4, PREADY held 0.
  - Required: exactly 4 ACCESS cycles, then PSEL = 0.
  - Required: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Backpressure: rsp_ready = 0 for 5 cycles with a new cmd_valid pending.
  - Required: rsp_* stable and cmd_ready = 0 throughout.
  - Required: after the handshake, the next command is accepted 1 cycle later.
- Reset mid-access: assert n_rst low during ACCESS.
  - Required: PSEL, PENABLE, rsp_valid and cmd_ready go 0 immediately.
  - Required: after release, state is IDLE with cmd_ready = 1 and no stale response.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus state encoding and default widths.
// No logic and no latency; referenced by both the requester and the completer sides.
// No flow control of its own.
package apb_pkg;

    // Phases of one APB transfer as seen by the requester.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Byte lanes per data word; register maps step addresses by this amount.
    localparam int APB_BYTES_PER_WORD = 4;

    // Default bus widths, shared by the completer side of the fabric.
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait states and flags when the wait budget is used up.
// expired is decoded from the count register, so it follows count_en by one cycle.
// clear has priority over count_en; the count saturates at the last budgeted cycle.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // Wide enough to hold TIMEOUT_CYCLES; a budget of 0 still needs one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value on the final allowed wait cycle. With no budget this is 0 and
    // the counter never moves, because it only advances while below LAST.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] cnt;

    // Advance on each wait-state cycle, stopping at LAST so the count can never wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The budget is spent once the final wait cycle is reached; a zero budget never expires.
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns one valid/ready command into one SETUP+ACCESS transfer and a response.
// Accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 plus any wait states.
// One command in flight; cmd_ready stays low until the response is taken with rsp_ready.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_t state;

    logic timer_clear;
    logic timer_count;
    logic timer_expired;

    // The wait counter only lives inside ACCESS and restarts from zero on every entry.
    assign timer_clear = (state != ACCESS);
    assign timer_count = (state == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    // Transfer sequencer; every bus and response output is a register written here.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Address, direction and data are frozen here for the whole transfer.
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        // Also raises ready on the first cycle after reset release.
                        cmd_ready <= 1'b1;
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (PREADY) begin
                        // A completion on the last budgeted cycle still counts as normal.
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (timer_expired) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    // Response fields hold until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
